axi_lite_cmd_master: RTL and testbench

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_lite_cmd_master.sv | 202 ++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
//   Turns single read/write commands into AXI4-Lite transactions, one at a
//   time, and reports each completion (or timeout) as a one-cycle pulse.
// Ports
//   m_axi_aclk, m_axi_areset      : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata/wstrb : command request side
//   m_axi_aw*/w*/b*/ar*/r*        : AXI4-Lite master channels
//   rsp_valid/rdata/resp/timeout  : completion report (rdata/resp held)
module axi_lite_cmd_master #(
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_areset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    output logic                              rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout
);

    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmo_cnt_q;
    logic            tmo_hit;
    logic            done;

    logic [AW-1:0]   awaddr_d, araddr_d;
    logic [DW-1:0]   wdata_d, rsp_rdata_d;
    logic [SW-1:0]   wstrb_d;
    logic            awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
    logic            rsp_valid_d, rsp_timeout_d;
    logic [1:0]      rsp_resp_d;

    assign cmd_ready = (state_q == IDLE);

    // Last allowed cycle of an outstanding transaction
    assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TW'(1));

    // Next-state and next-value of every registered output
    always_comb begin
        state_d       = state_q;
        awaddr_d      = m_axi_awaddr;
        wdata_d       = m_axi_wdata;
        wstrb_d       = m_axi_wstrb;
        araddr_d      = m_axi_araddr;
        awvalid_d     = m_axi_awvalid;
        wvalid_d      = m_axi_wvalid;
        bready_d      = m_axi_bready;
        arvalid_d     = m_axi_arvalid;
        rready_d      = m_axi_rready;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rsp_timeout_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WRITE: begin
                // AW and W retire independently; a retired valid stays low
                awvalid_d = m_axi_awvalid && !m_axi_awready;
                wvalid_d  = m_axi_wvalid && !m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    done        = 1'b1;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    state_d     = IDLE;
                end
            end
            RADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    done        = 1'b1;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion on the final cycle wins over the timeout
        if (tmo_hit && !done) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            state_d       = IDLE;
        end
    end

    // State, timeout counter and output registers
    always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
        if (m_axi_areset) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_araddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_timeout   <= 1'b0;
        end else begin
            state_q       <= state_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_wdata   <= wdata_d;
            m_axi_wstrb   <= wstrb_d;
            m_axi_araddr  <= araddr_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            if (state_q == IDLE) begin
                if (cmd_valid) begin
                    tmo_cnt_q <= TW'(TIMEOUT_CYCLES);
                end
            end else begin
                tmo_cnt_q <= tmo_cnt_q - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Testbench for axi_lite_cmd_master: a slave with per-transaction random
// wait states, a queue of expected completions filled at command issue, and
// an independent monitor that pops and compares on every rsp_valid.
module tb_axi_lite_cmd_master;

    localparam int TMO = 255;

    logic        m_axi_aclk = 1'b0;
    logic        m_axi_areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic [7:0]  m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [7:0]  m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .m_axi_aclk(m_axi_aclk), .m_axi_areset(m_axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout)
    );

    initial forever #5 m_axi_aclk = ~m_axi_aclk;

    // Number of rising edges seen so far
    int edge_n = 0;
    always @(posedge m_axi_aclk) edge_n <= edge_n + 1;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          edge_at;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   nchk = 0;
    int   nerr = 0;
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_resp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge m_axi_aclk);
        #1;
    endtask

    // Monitor: compares each completion with the head of the expected queue
    always @(negedge m_axi_aclk) begin
        if (m_axi_areset) begin
            last_rdata = '0;
            last_resp  = '0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
                me = exp_q.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(me.rdata));
                chk("rsp_resp", 64'(rsp_resp), 64'(me.resp));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(me.tmo));
                chk("rsp_cycle", 64'(edge_n), 64'(me.edge_at));
                last_rdata = me.rdata;
                last_resp  = me.resp;
            end
        end else begin
            chk("rsp_hold", 64'({rsp_rdata, rsp_resp}), 64'({last_rdata, last_resp}));
        end
    end

    task automatic clear_slave();
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = '0;
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    endtask

    // Issue one command and act as the slave. d1: AW (write) or AR (read)
    // ready delay, d2: W ready delay, d3: B/R valid delay after ready.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int d1, input int d2, input int d3,
                           input logic [1:0] sresp, input logic [31:0] srdata, input logic never);
        exp_t e;
        int   a_edge, c;
        int   aw_n, w_n, b_n, ar_n, r_n, aw_e, w_e, ar_e;
        int   aw_w, w_w, ar_w, x_w;
        bit   done;
        logic pav, pwv, pbr, parv, prr;

        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        tick();
        a_edge = edge_n;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = 8'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);

        // Completion edge relative to accept: address/data phase, then response
        c = wr ? (((d1 > d2) ? d1 : d2) + 2 + d3) : (d1 + 2 + d3);
        e.tmo     = never || (c > TMO);
        e.edge_at = a_edge + (e.tmo ? TMO : c);
        e.resp    = e.tmo ? 2'b10 : sresp;
        e.rdata   = (e.tmo || wr) ? 32'd0 : srdata;
        exp_q.push_back(e);

        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_e = -1; w_e = -1; ar_e = -1;
        aw_w = d1; w_w = d2; ar_w = d1; x_w = d3;
        pav = 0; pwv = 0; pbr = 0; parv = 0; prr = 0;
        done = 0;
        for (int n = 0; n < TMO + 20 && !done; n++) begin
            if (pav && m_axi_awready) begin aw_n++; aw_e = edge_n; end
            if (pwv && m_axi_wready) begin w_n++; w_e = edge_n; end
            if (parv && m_axi_arready) begin ar_n++; ar_e = edge_n; end
            if (pbr && m_axi_bvalid) b_n++;
            if (prr && m_axi_rvalid) r_n++;
            if (n == 0) chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            if (cmd_ready) begin
                done = 1;
            end else begin
                if (m_axi_awvalid) chk("awaddr_stable", 64'(m_axi_awaddr), 64'(addr));
                if (m_axi_wvalid) chk("wdata_stable", 64'({m_axi_wdata, m_axi_wstrb}), 64'({data, strb}));
                if (m_axi_arvalid) chk("araddr_stable", 64'(m_axi_araddr), 64'(addr));
                m_axi_awready = m_axi_awvalid && (aw_w == 0);
                if (m_axi_awvalid && aw_w > 0) aw_w--;
                m_axi_wready = m_axi_wvalid && (w_w == 0);
                if (m_axi_wvalid && w_w > 0) w_w--;
                m_axi_arready = m_axi_arvalid && (ar_w == 0);
                if (m_axi_arvalid && ar_w > 0) ar_w--;
                if (wr) begin
                    m_axi_bvalid = m_axi_bready && !never && (x_w == 0);
                    if (m_axi_bready && x_w > 0) x_w--;
                    m_axi_bresp  = m_axi_bvalid ? sresp : 2'($urandom);
                    m_axi_rvalid = 1'($urandom);     // stray, must be ignored
                    m_axi_rdata  = $urandom;
                    m_axi_rresp  = 2'($urandom);
                end else begin
                    m_axi_rvalid = m_axi_rready && !never && (x_w == 0);
                    if (m_axi_rready && x_w > 0) x_w--;
                    m_axi_rdata  = m_axi_rvalid ? srdata : $urandom;
                    m_axi_rresp  = m_axi_rvalid ? sresp : 2'($urandom);
                    m_axi_bvalid = 1'($urandom);     // stray, must be ignored
                    m_axi_bresp  = 2'($urandom);
                end
                pav = m_axi_awvalid; pwv = m_axi_wvalid; parv = m_axi_arvalid;
                pbr = m_axi_bready;  prr = m_axi_rready;
                tick();
            end
        end
        if (!done) chk("txn_return_idle", 64'd0, 64'd1);
        if (!e.tmo) begin
            if (wr) begin
                chk("aw_handshakes", 64'(aw_n), 64'd1);
                chk("w_handshakes", 64'(w_n), 64'd1);
                chk("b_handshakes", 64'(b_n), 64'd1);
                chk("aw_cycle", 64'(aw_e), 64'(a_edge + 1 + d1));
                chk("w_cycle", 64'(w_e), 64'(a_edge + 1 + d2));
            end else begin
                chk("ar_handshakes", 64'(ar_n), 64'd1);
                chk("r_handshakes", 64'(r_n), 64'd1);
                chk("ar_cycle", 64'(ar_e), 64'(a_edge + 1 + d1));
            end
        end else begin
            chk("no_resp_handshake_on_timeout", 64'(b_n + r_n), 64'd0);
        end
        clear_slave();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_slave();
        repeat (3) tick();
        chk("reset_outputs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                   m_axi_rready, rsp_valid, rsp_timeout, rsp_resp}), 64'd0);
        chk("reset_buses", 64'({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr}), 64'd0);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        m_axi_areset = 1'b0;
        tick();

        // Directed cases
        run_txn(1'b1, 8'h10, 32'h0000ABCD, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1'b0);
        run_txn(1'b1, 8'h20, 32'h12345678, 4'h3, 3, 0, 0, 2'b00, 32'h0, 1'b0);
        run_txn(1'b0, 8'h24, 32'h0, 4'h0, 0, 0, 2, 2'b00, 32'hDEADBEEF, 1'b0);
        run_txn(1'b1, 8'h30, 32'hCAFEF00D, 4'h1, 0, 0, 0, 2'b00, 32'h0, 1'b1);
        run_txn(1'b1, 8'h44, 32'h55AA55AA, 4'hC, 0, 2, 1, 2'b10, 32'h0, 1'b0);
        run_txn(1'b0, 8'h48, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h01020304, 1'b0);

        // Reset while waiting in RDATA
        cmd_write = 1'b0; cmd_addr = 8'h24; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        m_axi_arready = 1'b1;
        tick();
        m_axi_arready = 1'b0;
        chk("rready_before_reset", 64'(m_axi_rready), 64'd1);
        #2;
        m_axi_areset = 1'b1;
        #1;
        chk("midreset_ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                   m_axi_rready, rsp_valid, rsp_timeout, rsp_resp}), 64'd0);
        chk("midreset_buses", 64'({m_axi_awaddr, m_axi_wdata, m_axi_wstrb, m_axi_araddr}), 64'd0);
        chk("midreset_rdata", 64'(rsp_rdata), 64'd0);
        chk("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (2) tick();
        m_axi_areset = 1'b0;
        tick();
        run_txn(1'b0, 8'h24, 32'h0, 4'h0, 0, 0, 1, 2'b01, 32'h600DF00D, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom), 8'($urandom), $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    2'($urandom), $urandom, ($urandom_range(0, 19) == 0));
        end

        repeat (4) tick();
        chk("expected_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
